board_mem_arbiter: RTL and testbench

//  Shares the single-port 11x11 board-state RAM between two requesters.

---
 rtl/hnefatafl_pkg.sv | 36 +++
 rtl/arb_starve_counter.sv | 43 ++++
 rtl/board_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_board_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hnefatafl_pkg.sv
// Shared constants and types for the hnefatafl board-state memory arbiter.
//  - Cell codes stored in the 11x11 board RAM.
//  - Board geometry and default arbiter widths.
//  - Game-side access FSM encoding and the display return-pipeline stage.
package hnefatafl_pkg;

    // Cell codes held in each board RAM word
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_ATT   = 2'b01;
    localparam logic [1:0] CELL_DEF   = 2'b10;
    localparam logic [1:0] CELL_KING  = 2'b11;

    // Board geometry: addresses at or above CELLS are off the board
    localparam int unsigned BOARD_N = 11;
    localparam int unsigned CELLS   = BOARD_N * BOARD_N;

    // Default arbiter sizing
    localparam int unsigned BOARD_ADDR_W   = 7;
    localparam int unsigned CELL_W         = 2;
    localparam int unsigned ARB_STARVE_MAX = 8;

    // Game-side access FSM
    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_ISSUE = 2'd1,
        GS_WAIT  = 2'd2
    } game_state_e;

    // One display request in flight between the arbitration edge and its result
    typedef struct packed {
        logic valid;   // a display request was sampled
        logic served;  // it won the slot (or needed no RAM)
        logic oor;     // address was off the board, data forced to zero
    } disp_stage_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive cycles the game requester was denied.
//  clk     in   system clock
//  rst     in   synchronous active-high reset
//  inc     in   game requested while idle and lost arbitration this cycle
//  clr     in   game granted or not requesting
//  at_max  out  registered: count has reached MAX
module arb_starve_counter #(
    parameter int unsigned MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CNT_W = $clog2(MAX + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Clear has priority; count up and stick at MAX
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc && (cnt != CNT_W'(MAX))) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // at_max is registered alongside the count so it always matches cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            at_max <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            at_max <= (cnt_nxt == CNT_W'(MAX));
        end
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Shares the single-port 11x11 board RAM between the VGA pixel path
// (read-only, fixed latency 2) and the game-logic FSM (req/ack reads and writes).
// Display has priority during active video unless the game has starved for
// STARVE_MAX cycles; the game has priority during vblank.
//  clk, rst                     clock, synchronous active-high reset
//  vblank                       vertical blanking from display timing
//  disp_req/disp_addr           display read request (one cycle per access)
//  disp_rvalid/disp_rdata       display data, two cycles after the request
//  disp_miss                    display request lost its slot
//  game_req/we/addr/wdata       game access, held until game_ack
//  game_ack/game_rdata          completion pulse, read data valid with ack on reads
//  mem_en/we/addr/wdata         registered RAM command
//  mem_rdata                    RAM read data, one cycle after mem_en
module board_mem_arbiter
    import hnefatafl_pkg::*;
#(
    parameter int unsigned ADDR_W     = BOARD_ADDR_W,
    parameter int unsigned DATA_W     = CELL_W,
    parameter int unsigned CELLS      = hnefatafl_pkg::CELLS,
    parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblank,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_miss,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_ack,
    output logic [DATA_W-1:0] game_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Arbitration terms for the current edge
    logic disp_oor;
    logic game_oor;
    logic game_cand;
    logic disp_need;
    logic game_need;
    logic game_first;
    logic game_grant;
    logic disp_served;
    logic starve_at_max;

    // Game FSM
    game_state_e state;
    game_state_e state_nxt;
    logic        ack_nxt;
    logic        op_we;
    logic        op_oor;

    // Display return pipeline
    disp_stage_t disp_s1;
    logic        disp_oor_q;

    // Priority mux: off-board requests never touch the RAM, so they are always
    // served and leave the slot to the other requester.
    always_comb begin
        disp_oor    = (32'(disp_addr) >= CELLS);
        game_oor    = (32'(game_addr) >= CELLS);
        game_cand   = game_req && (state == GS_IDLE);
        disp_need   = disp_req && !disp_oor;
        game_need   = game_cand && !game_oor;
        game_first  = vblank || starve_at_max;
        game_grant  = game_cand && (game_oor || !disp_need || game_first);
        disp_served = disp_req && (disp_oor || !game_need || !game_first);
    end

    // Starvation tracking only while the game is waiting in IDLE
    arb_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (game_cand && !game_grant),
        .clr    (game_grant || !game_req),
        .at_max (starve_at_max)
    );

    // Game FSM next state; writes ack in ISSUE, reads ack in WAIT
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        case (state)
            GS_IDLE: begin
                if (game_grant) begin
                    state_nxt = GS_ISSUE;
                    ack_nxt   = game_we;
                end
            end
            GS_ISSUE: begin
                if (op_we) begin
                    state_nxt = GS_IDLE;
                end else begin
                    state_nxt = GS_WAIT;
                    ack_nxt   = 1'b1;
                end
            end
            GS_WAIT: begin
                state_nxt = GS_IDLE;
            end
            default: begin
                state_nxt = GS_IDLE;
            end
        endcase
    end

    // Game FSM state, ack and captured operation attributes
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= GS_IDLE;
            game_ack <= 1'b0;
            op_we    <= 1'b0;
            op_oor   <= 1'b0;
        end else begin
            state    <= state_nxt;
            game_ack <= ack_nxt;
            if ((state == GS_IDLE) && game_grant) begin
                op_we  <= game_we;
                op_oor <= game_oor;
            end
        end
    end

    // RAM command register; address and write data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (disp_served && disp_need) begin
                mem_en   <= 1'b1;
                mem_addr <= disp_addr;
            end else if (game_grant && game_need) begin
                mem_en   <= 1'b1;
                mem_we   <= game_we;
                mem_addr <= game_addr;
                if (game_we) begin
                    mem_wdata <= game_wdata;
                end
            end
        end
    end

    // Display result: stage 1 at the arbitration edge, flags one edge later
    // so they line up with mem_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_s1     <= '0;
            disp_rvalid <= 1'b0;
            disp_miss   <= 1'b0;
            disp_oor_q  <= 1'b0;
        end else begin
            disp_s1.valid  <= disp_req;
            disp_s1.served <= disp_served;
            disp_s1.oor    <= disp_oor;
            disp_rvalid    <= disp_s1.valid && disp_s1.served;
            disp_miss      <= disp_s1.valid && !disp_s1.served;
            disp_oor_q     <= disp_s1.oor;
        end
    end

    // Read data arrives from the RAM in the same cycle as the registered flags;
    // it is gated to zero when not valid or when the address was off the board.
    always_comb begin
        disp_rdata = '0;
        game_rdata = '0;
        if (disp_rvalid && !disp_oor_q) begin
            disp_rdata = mem_rdata;
        end
        if ((state == GS_WAIT) && !op_oor) begin
            game_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a read-first single-port RAM model.
module tb_board_mem_arbiter;
    import hnefatafl_pkg::*;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              vblank;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_miss;
    logic              game_req;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [DATA_W-1:0] game_wdata;
    logic              game_ack;
    logic [DATA_W-1:0] game_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    board_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .vblank      (vblank),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .disp_miss   (disp_miss),
        .game_req    (game_req),
        .game_we     (game_we),
        .game_addr   (game_addr),
        .game_wdata  (game_wdata),
        .game_ack    (game_ack),
        .game_rdata  (game_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Read-first RAM model; ram_load preloads the board on the first edge
    logic [DATA_W-1:0] ram [0:127];
    logic              ram_load = 1'b1;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 128; i++) ram[i] <= '0;
            ram[60]   <= CELL_KING;
            mem_rdata <= '0;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation time 50000 reached, required completion earlier");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int ack_tick, ack_cnt, miss_tick, miss_cnt, rv_cnt;
    logic [8:0] wr_cmd;

    initial begin
        rst = 1'b1; vblank = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        game_req = 1'b0; game_we = 1'b0; game_addr = '0; game_wdata = '0;

        // 1. Reset held 3 cycles with requests toggling
        for (int i = 0; i < 3; i++) begin
            disp_req  = i[0];
            game_req  = !i[0];
            game_addr = 7'(i);
            disp_addr = 7'(60);
            tick();
            ram_load = 1'b0;
            check_eq("reset_outputs",
                     32'({disp_rvalid, disp_rdata, disp_miss, game_ack, game_rdata,
                          mem_en, mem_we, mem_addr, mem_wdata}), 0);
        end

        // 2. Active video, display streaming address 60
        rst = 1'b0; game_req = 1'b0; vblank = 1'b0;
        disp_req = 1'b1; disp_addr = 7'd60;
        tick();
        check_eq("first_grant_en", 32'(mem_en), 1);
        check_eq("first_grant_addr", 32'(mem_addr), 60);
        check_eq("first_rvalid_low", 32'(disp_rvalid), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("disp_rvalid", 32'(disp_rvalid), 1);
            check_eq("disp_rdata", 32'(disp_rdata), 32'(CELL_KING));
            check_eq("disp_miss_low", 32'(disp_miss), 0);
        end

        // 3. Game write starves behind the display, then is forced through
        game_req = 1'b1; game_we = 1'b1; game_addr = 7'd5; game_wdata = CELL_ATT;
        ack_tick = 0; ack_cnt = 0; miss_tick = 0; miss_cnt = 0; rv_cnt = 0; wr_cmd = '0;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (game_ack) begin
                ack_cnt++;
                ack_tick = t;
                wr_cmd   = {mem_en, mem_we, mem_addr};
                game_req = 1'b0;
            end
            if (disp_miss) begin
                miss_cnt++;
                miss_tick = t;
            end
            if (disp_rvalid) rv_cnt++;
        end
        check_eq("starve_ack_cnt", 32'(ack_cnt), 1);
        check_eq("starve_ack_tick", 32'(ack_tick), 9);
        check_eq("starve_wr_cmd", 32'(wr_cmd), 32'({1'b1, 1'b1, 7'd5}));
        check_eq("starve_miss_cnt", 32'(miss_cnt), 1);
        check_eq("starve_miss_tick", 32'(miss_tick), 10);
        check_eq("starve_rvalid_cnt", 32'(rv_cnt), 13);
        check_eq("ram5_written", 32'(ram[5]), 32'(CELL_ATT));

        // 4. vblank: game read wins over a simultaneous display request
        vblank = 1'b1; game_req = 1'b1; game_we = 1'b0; game_addr = 7'd5;
        tick();
        check_eq("vb_mem_cmd", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 7'd5}));
        check_eq("vb_ack_early", 32'(game_ack), 0);
        tick();
        check_eq("vb_game_ack", 32'(game_ack), 1);
        check_eq("vb_game_rdata", 32'(game_rdata), 32'(CELL_ATT));
        check_eq("vb_disp_miss", 32'(disp_miss), 1);
        check_eq("vb_disp_rvalid", 32'(disp_rvalid), 0);
        game_req = 1'b0; disp_req = 1'b0;
        tick();
        check_eq("vb_ack_done", 32'(game_ack), 0);
        check_eq("vb_disp_after", 32'({disp_rvalid, disp_rdata}), 32'({1'b1, CELL_KING}));
        // Idle slot: command deasserted, address and data hold
        check_eq("idle_hold", 32'({mem_en, mem_we, mem_addr, mem_wdata}),
                 32'({1'b0, 1'b0, 7'd60, CELL_ATT}));

        // 5a. Off-board game write leaves the slot to the display
        game_req = 1'b1; game_we = 1'b1; game_addr = 7'd121; game_wdata = CELL_DEF;
        disp_req = 1'b1; disp_addr = 7'd60;
        tick();
        check_eq("oor_wr_ack", 32'(game_ack), 1);
        check_eq("oor_wr_slot", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 7'd60}));
        game_req = 1'b0; disp_req = 1'b0;
        tick();
        check_eq("oor_wr_ack_done", 32'(game_ack), 0);
        check_eq("oor_wr_disp", 32'({disp_rvalid, disp_rdata}), 32'({1'b1, CELL_KING}));
        check_eq("oor_wr_ram", 32'(ram[121]), 32'(CELL_EMPTY));

        // 5b. Off-board display read returns zero without a RAM cycle
        disp_req = 1'b1; disp_addr = 7'd127;
        tick();
        check_eq("oor_rd_mem_en", 32'(mem_en), 0);
        disp_req = 1'b0;
        tick();
        check_eq("oor_rd_disp", 32'({disp_rvalid, disp_rdata, disp_miss}),
                 32'({1'b1, 2'b00, 1'b0}));

        // 5c. Off-board game read acks with zero data
        game_req = 1'b1; game_we = 1'b0; game_addr = 7'd125;
        tick();
        check_eq("oor_grd_issue", 32'({mem_en, game_ack}), 0);
        tick();
        check_eq("oor_grd_ack", 32'({game_ack, game_rdata}), 32'({1'b1, 2'b00}));
        game_req = 1'b0;
        tick();

        // 6. Reset lands on the edge that would complete a game read
        game_req = 1'b1; game_we = 1'b0; game_addr = 7'd60;
        tick();
        check_eq("rst_rd_issue", 32'({mem_en, game_ack}), 32'({1'b1, 1'b0}));
        rst = 1'b1;
        tick();
        check_eq("rst_rd_no_ack", 32'({game_ack, mem_en}), 0);
        rst = 1'b0;
        tick();
        check_eq("rst_rd_regrant", 32'({mem_en, mem_addr, game_ack}), 32'({1'b1, 7'd60, 1'b0}));
        tick();
        check_eq("rst_rd_ack", 32'({game_ack, game_rdata}), 32'({1'b1, CELL_KING}));
        game_req = 1'b0;
        tick();
        check_eq("rst_rd_ack_done", 32'(game_ack), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
